seg_scan_capture: RTL

- Receive-side counterpart of the 7-segment digit decoder: samples a multiplexed, active-low 7-segment display bus and recovers the 5-bit signed digit value shown on each position.
- Filters strobe/segment transitions and validates each pattern against the decoder table.
- Assembles one frame per full display scan and hands it off through a valid/ready handshake.
- Used for loop-back self-test of the display path and for sniffing external display boards.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg_scan_capture_seg_to_digit.sv | 47 ++++
 rtl/seg_scan_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan capture path: segment patterns,
// recovered digit type and capture FSM states.
package seg_pkg;

    // Active-high segment patterns, bit7..bit0 = A,B,C,D,E,F,G,DP.
    localparam int         DP_BIT    = 0;
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef logic [4:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    function automatic logic [7:0] seg_pattern(input logic [3:0] n);
        case (n)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg_to_digit.sv
// Inverse of the digit decoder: active-low segment pattern to signed 5-bit
// value, with flags for blank and unrecognised patterns.
module seg_to_digit
    import seg_pkg::*;
(
    input  logic [7:0] seg_n,
    output digit_t     value,
    output logic       err,
    output logic       blank
);

    logic [7:0] pat;
    logic [7:0] pat_nodp;
    logic       hit;
    logic [3:0] mag;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave a value unassigned (latch).
    always_comb begin
        pat              = ~seg_n;
        pat_nodp         = pat;
        pat_nodp[DP_BIT] = 1'b0;
        value            = '0;
        err              = 1'b0;
        blank            = 1'b0;
        hit              = 1'b0;
        mag              = '0;
        for (int n = 0; n < 16; n++) begin
            if (pat_nodp == seg_pattern(4'(n))) begin
                hit = 1'b1;
                mag = 4'(n);
            end
        end
        if (pat == SEG_BLANK) begin
            blank = 1'b1;
        end else if (!hit) begin
            err = 1'b1;
        end else if (!pat[DP_BIT]) begin
            value = {1'b0, mag};
        end else if (mag == 4'd0) begin
            value = 5'b10000;   // "-0" is the only encoding of -16
        end else begin
            value = -{1'b0, mag};
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit
// position and delivers one frame per complete scan over valid/ready.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg_n,
    input  logic [DIGITS-1:0]   dig_n,
    output logic [5*DIGITS-1:0] frame_value,
    output logic [DIGITS-1:0]   frame_err,
    output logic [DIGITS-1:0]   frame_blank,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overrun
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]       STABLE   = 8'(STABLE_CYCLES);

    logic [7:0]        seg_q;
    logic [DIGITS-1:0] dig_q;
    logic [DIGITS-1:0] sel;
    logic              onehot;
    logic [IDX_W-1:0]  sel_idx;

    state_t            state_q, state_d;
    logic [DIGITS-1:0] dig_lat_q, dig_lat_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        pat_q, pat_d;
    logic [7:0]        count_q, count_d;
    logic              capture;

    digit_t [DIGITS-1:0] slot_val_q, slot_val_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [DIGITS-1:0]   mask_q, mask_cap;
    logic                last_cap, complete, load;

    digit_t dec_val;
    logic   dec_err, dec_blank;

    seg_to_digit u_dec (
        .seg_n (pat_q),
        .value (dec_val),
        .err   (dec_err),
        .blank (dec_blank)
    );

    always_comb begin
        sel     = ~dig_q;
        onehot  = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        dig_lat_d = dig_lat_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        count_d   = count_q;
        capture   = 1'b0;
        if (state_q == ST_SETTLE) begin
            if (dig_q == dig_lat_q && seg_q == pat_q) begin
                count_d = count_q + 8'd1;
                if (count_d == STABLE) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end else begin
                dig_lat_d = dig_q;
                idx_d     = sel_idx;
                pat_d     = seg_q;
                count_d   = 8'd1;
                if (!onehot) state_d = ST_IDLE;
            end
        end else if (state_q == ST_IDLE || dig_q != dig_lat_q) begin
            // HOLD only releases on a strobe change, then acts exactly like IDLE.
            if (onehot) begin
                dig_lat_d = dig_q;
                idx_d     = sel_idx;
                pat_d     = seg_q;
                count_d   = 8'd1;
                state_d   = ST_SETTLE;
            end else begin
                state_d   = ST_IDLE;
            end
        end
    end

    always_comb begin
        slot_val_d   = slot_val_q;
        slot_err_d   = slot_err_q;
        slot_blank_d = slot_blank_q;
        mask_cap     = mask_q;
        if (capture) begin
            slot_val_d[idx_q]   = dec_val;
            slot_err_d[idx_q]   = dec_err;
            slot_blank_d[idx_q] = dec_blank;
            mask_cap[idx_q]     = 1'b1;
        end
        last_cap = capture && (idx_q == LAST_IDX);
        complete = last_cap && (&mask_cap);
        load     = complete && (!frame_valid || frame_ready);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= 8'hFF;
            dig_q        <= '1;
            state_q      <= ST_IDLE;
            dig_lat_q    <= '1;
            idx_q        <= '0;
            pat_q        <= 8'hFF;
            count_q      <= '0;
            // NOTE: the slot store is a few flops, not a RAM, so clearing it
            // on reset is cheap and keeps stale digits out of the next frame.
            slot_val_q   <= '0;
            slot_err_q   <= '0;
            slot_blank_q <= '0;
            mask_q       <= '0;
            frame_value  <= '0;
            frame_err    <= '0;
            frame_blank  <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            seg_q        <= seg_n;
            dig_q        <= dig_n;
            state_q      <= state_d;
            dig_lat_q    <= dig_lat_d;
            idx_q        <= idx_d;
            pat_q        <= pat_d;
            count_q      <= count_d;
            slot_val_q   <= slot_val_d;
            slot_err_q   <= slot_err_d;
            slot_blank_q <= slot_blank_d;
            mask_q       <= last_cap ? '0 : mask_cap;
            overrun      <= complete && frame_valid && !frame_ready;
            if (load) begin
                frame_value <= slot_val_d;
                frame_err   <= slot_err_d;
                frame_blank <= slot_blank_d;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
